// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage F/D/E/M/W pipeline: stall/bubble generation,
// operand forwarding selects, and multiply/divide busy sequencing.
module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d_valid,
    input  logic [4:0] d_rs_addr,
    input  logic [4:0] d_rt_addr,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst_addr,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       pc_enable,
    output logic       d_enable,
    output logic       e_flush,
    output logic [1:0] fm_d1,
    output logic [1:0] fm_d2,
    output logic [1:0] fm_e1,
    output logic [1:0] fm_e2,
    output logic       md_busy
);

    logic [4:0]       e_dst, e_rs, e_rt, m_dst, w_dst;
    logic [1:0]       e_tnew, m_tnew;
    logic             e_md, e_div;
    logic [CNT_W-1:0] md_cnt;

    logic hz_rs, hz_rt, hz_md, stall;

    function automatic logic src_hazard(
        input logic [4:0] addr,
        input logic [1:0] tuse,
        input logic [4:0] edst,
        input logic [1:0] etnew,
        input logic [4:0] mdst,
        input logic [1:0] mtnew
    );
        logic hit;
        hit = 1'b0;
        if (addr != 5'd0 && tuse != 2'd3) begin
            if (edst == addr && etnew > tuse) hit = 1'b1;
            if (mdst == addr && mtnew > tuse) hit = 1'b1;
        end
        return hit;
    endfunction

    // Younger producer is checked first so it wins on a multiple match.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] addr,
        input logic [4:0] young_dst,
        input logic       young_rdy,
        input logic [4:0] old_dst,
        input logic       old_rdy
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (addr != 5'd0) begin
            if (young_dst == addr && young_rdy)    sel = 2'd1;
            else if (old_dst == addr && old_rdy)   sel = 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        hz_rs = src_hazard(d_rs_addr, d_tuse_rs, e_dst, e_tnew, m_dst, m_tnew);
        hz_rt = src_hazard(d_rt_addr, d_tuse_rt, e_dst, e_tnew, m_dst, m_tnew);
        hz_md = d_md_use && ((md_cnt != '0) || e_md);
        stall = d_valid && (hz_rs || hz_rt || hz_md);

        pc_enable = !stall;
        d_enable  = !stall;
        e_flush   = stall;

        // W never needs a D-stage select: the register file writes through.
        fm_d1 = fwd_sel(d_rs_addr, e_dst, (e_tnew == 2'd0), m_dst, (m_tnew == 2'd0));
        fm_d2 = fwd_sel(d_rt_addr, e_dst, (e_tnew == 2'd0), m_dst, (m_tnew == 2'd0));
        fm_e1 = fwd_sel(e_rs, m_dst, (m_tnew == 2'd0), w_dst, 1'b1);
        fm_e2 = fwd_sel(e_rt, m_dst, (m_tnew == 2'd0), w_dst, 1'b1);

        md_busy = (md_cnt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_dst  <= 5'd0;
            e_tnew <= 2'd0;
            e_rs   <= 5'd0;
            e_rt   <= 5'd0;
            e_md   <= 1'b0;
            e_div  <= 1'b0;
            m_dst  <= 5'd0;
            m_tnew <= 2'd0;
            w_dst  <= 5'd0;
            md_cnt <= '0;
        end else begin
            if (stall || !d_valid) begin
                e_dst  <= 5'd0;
                e_tnew <= 2'd0;
                e_rs   <= 5'd0;
                e_rt   <= 5'd0;
                e_md   <= 1'b0;
                e_div  <= 1'b0;
            end else begin
                e_dst  <= d_dst_addr;
                e_tnew <= d_tnew;
                e_rs   <= d_rs_addr;
                e_rt   <= d_rt_addr;
                e_md   <= d_md_start;
                e_div  <= d_md_div;
            end

            m_dst  <= e_dst;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            w_dst  <= m_dst;

            // The count starts as the mult/div leaves E; e_md covers its cycle in E.
            if (e_md)
                md_cnt <= e_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of D-stage vectors with hand-derived
// expected outputs, checked through a scoreboard queue, plus an async-reset sequence.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       d_valid;
    logic [4:0] d_rs_addr, d_rt_addr, d_dst_addr;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       pc_enable, d_enable, e_flush, md_busy;
    logic [1:0] fm_d1, fm_d2, fm_e1, fm_e2;

    hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_valid    (d_valid),
        .d_rs_addr  (d_rs_addr),
        .d_rt_addr  (d_rt_addr),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_dst_addr (d_dst_addr),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .pc_enable  (pc_enable),
        .d_enable   (d_enable),
        .e_flush    (e_flush),
        .fm_d1      (fm_d1),
        .fm_d2      (fm_d2),
        .fm_e1      (fm_e1),
        .fm_e2      (fm_e2),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [1:0] trs;
        logic [4:0] rt;
        logic [1:0] trt;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       mds, mdd, mdu;
        logic [11:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Expected word: {pc_enable, d_enable, e_flush, fm_d1, fm_d2, fm_e1, fm_e2, md_busy}
    function automatic logic [11:0] mk_exp(input logic stall, input logic [1:0] fd1,
        input logic [1:0] fd2, input logic [1:0] fe1, input logic [1:0] fe2, input logic busy);
        return {~stall, ~stall, stall, fd1, fd2, fe1, fe2, busy};
    endfunction

    function automatic vec_t v(input logic valid, input logic [4:0] rs, input logic [1:0] trs,
        input logic [4:0] rt, input logic [1:0] trt, input logic [4:0] dst, input logic [1:0] tnew,
        input logic mds, input logic mdd, input logic mdu, input logic stall,
        input logic [1:0] fd1, input logic [1:0] fd2, input logic [1:0] fe1,
        input logic [1:0] fe2, input logic busy);
        vec_t r;
        r.valid = valid; r.rs = rs; r.trs = trs; r.rt = rt; r.trt = trt;
        r.dst = dst; r.tnew = tnew; r.mds = mds; r.mdd = mdd; r.mdu = mdu;
        r.exp = mk_exp(stall, fd1, fd2, fe1, fe2, busy);
        return r;
    endfunction

    task automatic drive(input vec_t x);
        d_valid = x.valid; d_rs_addr = x.rs; d_tuse_rs = x.trs;
        d_rt_addr = x.rt; d_tuse_rt = x.trt; d_dst_addr = x.dst; d_tnew = x.tnew;
        d_md_start = x.mds; d_md_div = x.mdd; d_md_use = x.mdu;
    endtask

    task automatic check(input string name);
        logic [11:0] act, want;
        act = {pc_enable, d_enable, e_flush, fm_d1, fm_d2, fm_e1, fm_e2, md_busy};
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %b", name, act);
        end else begin
            want = sb.pop_front();
            if (act !== want) begin
                n_bad++;
                $display("FAIL %s: got %b want %b (pc,den,flush,fd1,fd2,fe1,fe2,busy)",
                         name, act, want);
            end
        end
    endtask

    task automatic apply(input vec_t x, input string name);
        @(posedge clk);
        #1;
        drive(x);
        sb.push_back(x.exp);
        @(negedge clk);
        check(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t nop, mfhi;
        nop  = v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mfhi = v(1, 0, 3, 0, 3, 19, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1);

        // lw $1 then addu rs=$1 tuse=1
        vecs.push_back(v(1, 5, 1, 0, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 6, 1, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 6, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(nop);
        // addu $2 then beq rs=$2 tuse=0
        vecs.push_back(v(1, 9, 1, 10, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 2, 0, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 2, 0, 8, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        // back-to-back writers of $3, younger-wins in E
        vecs.push_back(v(1, 11, 1, 12, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 3, 1, 13, 1, 14, 1, 0, 0, 0, 0, 2, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(nop);
        // $0 never hazards or forwards
        vecs.push_back(v(1, 11, 1, 12, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // tnew=0 producer in E forwards to D, then from M to E
        vecs.push_back(v(1, 15, 0, 15, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(nop);
        // d_valid=0 masks a hazard; tuse=3 ignores a match
        vecs.push_back(v(1, 0, 3, 0, 3, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 4, 0, 4, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 4, 0, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop);
        // mult then mflo: 6 stall cycles, busy for 5
        vecs.push_back(v(1, 16, 1, 17, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 3, 0, 3, 18, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(v(1, 0, 3, 0, 3, 18, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 3, 0, 3, 18, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop);

        rst_n = 1'b0;
        drive(nop);
        #3;
        sb.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        check("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // div in flight, reset pulled mid-count
        apply(v(1, 16, 1, 17, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), "div_issue");
        mfhi.exp = mk_exp(1, 0, 0, 0, 0, 0);
        apply(mfhi, "mfhi_stall_emd");
        mfhi.exp = mk_exp(1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++)
            apply(mfhi, $sformatf("mfhi_stall_busy%0d", k));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        check("rst_async_mid_div");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sb.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        check("rst_release");
        mfhi.exp = mk_exp(0, 0, 0, 0, 0, 0);
        apply(mfhi, "mfhi_after_rst");

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
